// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared slot type and forward-select sizing for the hazard scoreboard
package hazard_scoreboard_pkg;

    // Register index width shared by the slot record and the matchers
    localparam int PIPE_REG_AW = 5;

    // One in-flight instruction past ID
    typedef struct packed {
        logic                   valid;
        logic [PIPE_REG_AW-1:0] rd;
        logic                   regwrite;
        logic                   memread;
    } slot_t;

    // Width of a forward select able to name slots 0..depth-1
    function automatic int fwd_sel_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - youngest-match and forwarding-availability encoder for one source operand
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int SEL_W    = fwd_sel_w(DEPTH)
) (
    input  slot_t [DEPTH-1:0]       slots,
    input  logic  [PIPE_REG_AW-1:0] rs,
    input  logic                    use_rs,
    output logic                    hazard,
    output logic  [SEL_W-1:0]       sel
);

    logic found;

    // Scan from EX outward; only the youngest writer of rs decides the outcome.
    // A match in the last slot is retiring into a write-first register file,
    // so it neither stalls nor forwards.
    always_comb begin
        hazard = 1'b0;
        sel    = '0;
        found  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && slots[i].valid && slots[i].regwrite &&
                slots[i].rd == rs && rs != '0 && use_rs) begin
                found = 1'b1;
                if (i < DEPTH - 1) begin
                    if (FWD_EN != 0 && (!slots[i].memread || i + 1 >= LOAD_LAT + 1)) begin
                        sel = SEL_W'(i + 1);
                    end else begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - in-flight destination tracker producing stall, forward selects and stall count
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = PIPE_REG_AW,
    parameter int FWD_EN   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [REG_AW-1:0]        id_rs1,
    input  logic [REG_AW-1:0]        id_rs2,
    input  logic                     id_use_rs1,
    input  logic                     id_use_rs2,
    input  logic [REG_AW-1:0]        id_rd,
    input  logic                     id_regwrite,
    input  logic                     id_memread,
    input  logic                     flush,
    output logic                     stall,
    output logic [$clog2(DEPTH)-1:0] fwd_sel1,
    output logic [$clog2(DEPTH)-1:0] fwd_sel2,
    output logic [31:0]              stall_cnt
);

    localparam int SEL_W = $clog2(DEPTH);

    slot_t [DEPTH-1:0] slots;
    slot_t             head;
    logic              haz1;
    logic              haz2;
    logic [SEL_W-1:0]  sel1;
    logic [SEL_W-1:0]  sel2;
    logic              issue;

    hazard_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .FWD_EN   (FWD_EN),
        .SEL_W    (SEL_W)
    ) u_match_rs1 (
        .slots  (slots),
        .rs     (id_rs1),
        .use_rs (id_use_rs1),
        .hazard (haz1),
        .sel    (sel1)
    );

    hazard_match #(
        .DEPTH    (DEPTH),
        .LOAD_LAT (LOAD_LAT),
        .FWD_EN   (FWD_EN),
        .SEL_W    (SEL_W)
    ) u_match_rs2 (
        .slots  (slots),
        .rs     (id_rs2),
        .use_rs (id_use_rs2),
        .hazard (haz2),
        .sel    (sel2)
    );

    // Stall only a live, unflushed instruction; a flush wins over a stall
    always_comb begin
        stall = id_valid && !flush && (haz1 || haz2);
        issue = id_valid && !stall && !flush;
        head  = '0;
        if (issue) begin
            head.valid    = 1'b1;
            head.rd       = id_rd;
            head.regwrite = id_regwrite;
            head.memread  = id_memread;
        end
    end

    // Advance every in-flight instruction one stage; the oldest falls off the end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots <= '0;
        end else begin
            slots <= {slots[DEPTH-2:0], head};
        end
    end

    // Forward selects follow the issuing instruction into EX; bubbles carry zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_sel1 <= '0;
            fwd_sel2 <= '0;
        end else begin
            fwd_sel1 <= issue ? sel1 : '0;
            fwd_sel2 <= issue ? sel2 : '0;
        end
    end

    // Saturating count of cycles spent stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
